// File: rtl/adder_2_selftest_if.sv
// Stimulus and result wires between the self-test stage and the 2-bit adder.
// The self-test drives the operands and reads back both adder result sets.
interface adder_2_selftest_if;
    logic       A0;
    logic       A1;
    logic       B0;
    logic       B1;
    logic       Cin;
    logic [1:0] Core_Sum;
    logic       Core_Cout;
    logic       S0;
    logic       S1;
    logic       Cout;

    modport master (
        output A0,
        output A1,
        output B0,
        output B1,
        output Cin,
        input  Core_Sum,
        input  Core_Cout,
        input  S0,
        input  S1,
        input  Cout
    );

    modport slave (
        input  A0,
        input  A1,
        input  B0,
        input  B1,
        input  Cin,
        output Core_Sum,
        output Core_Cout,
        output S0,
        output S1,
        output Cout
    );
endinterface

// File: rtl/adder_2_selftest.sv
// Exhaustive self-test of a 2-bit adder: sweeps all 32 operand vectors and
// checks the core and structural result sets against a golden sum.
module adder_2_selftest #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                START,
    adder_2_selftest_if.master  bus,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [5:0]          CORE_ERR_CNT,
    output logic [5:0]          STR_ERR_CNT,
    output logic [4:0]          CORE_FIRST_ERR,
    output logic [4:0]          STR_FIRST_ERR,
    output logic                CORE_ERR_SEEN,
    output logic                STR_ERR_SEEN
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] RELOAD   = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] LAST_VEC = 5'd31;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] vec;
    logic [3:0] settle_cnt;
    logic [5:0] core_cnt;
    logic [5:0] str_cnt;
    logic [4:0] core_first;
    logic [4:0] str_first;
    logic       core_seen;
    logic       str_seen;

    logic       start_run;
    logic [2:0] golden;
    logic [2:0] core_res;
    logic [2:0] str_res;
    logic       core_bad;
    logic       str_bad;

    // START only counts when no sweep is in flight.
    assign start_run = START && ((state == S_IDLE) || (state == S_DONE));

    assign bus.A1  = vec[4];
    assign bus.A0  = vec[3];
    assign bus.B1  = vec[2];
    assign bus.B0  = vec[1];
    assign bus.Cin = vec[0];

    assign golden   = {1'b0, vec[4:3]} + {1'b0, vec[2:1]} + {2'b00, vec[0]};
    assign core_res = {bus.Core_Cout, bus.Core_Sum};
    assign str_res  = {bus.Cout, bus.S1, bus.S0};
    assign core_bad = (core_res != golden);
    assign str_bad  = (str_res != golden);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_run) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (vec == LAST_VEC) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                if (start_run) begin
                    state_nxt = S_SETTLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        PASS = 1'b0;
        unique case (state)
            S_SETTLE: begin
                BUSY = 1'b1;
            end
            S_CHECK: begin
                BUSY = 1'b1;
            end
            S_DONE: begin
                DONE = 1'b1;
                PASS = (core_cnt == 6'd0) && (str_cnt == 6'd0);
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            vec        <= 5'd0;
            settle_cnt <= 4'd0;
            core_cnt   <= 6'd0;
            str_cnt    <= 6'd0;
            core_first <= 5'd0;
            str_first  <= 5'd0;
            core_seen  <= 1'b0;
            str_seen   <= 1'b0;
        end else if (start_run) begin
            vec        <= 5'd0;
            settle_cnt <= RELOAD;
            core_cnt   <= 6'd0;
            str_cnt    <= 6'd0;
            core_first <= 5'd0;
            str_first  <= 5'd0;
            core_seen  <= 1'b0;
            str_seen   <= 1'b0;
        end else if (state == S_SETTLE) begin
            if (settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end else if (state == S_CHECK) begin
            // Each implementation keeps its own count and first failure.
            if (core_bad) begin
                core_cnt <= core_cnt + 6'd1;
                if (!core_seen) begin
                    core_first <= vec;
                    core_seen  <= 1'b1;
                end
            end
            if (str_bad) begin
                str_cnt <= str_cnt + 6'd1;
                if (!str_seen) begin
                    str_first <= vec;
                    str_seen  <= 1'b1;
                end
            end
            if (vec != LAST_VEC) begin
                vec        <= vec + 5'd1;
                settle_cnt <= RELOAD;
            end
        end
    end

    assign CORE_ERR_CNT   = core_cnt;
    assign STR_ERR_CNT    = str_cnt;
    assign CORE_FIRST_ERR = core_first;
    assign STR_FIRST_ERR  = str_first;
    assign CORE_ERR_SEEN  = core_seen;
    assign STR_ERR_SEEN   = str_seen;

endmodule
